// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

   localparam int unsigned REG_W_DEF        = 5;
   localparam int unsigned MEM_TIMEOUT_DEF  = 255;
   localparam int unsigned DRAIN_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } state_t;

   // Per-cycle pipeline control bundle produced by the output decode.
   typedef struct packed {
      logic mem_req;
      logic pc_stall;
      logic pc_sel_branch;
      logic stall_if_id;
      logic stall_id_ex;
      logic stall_ex_mem;
      logic flush_if_id;
      logic flush_id_ex;
      logic flush_ex_mem;
      logic flush_mem_wb;
   } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Data/sprite memory request/ready handshake seen by the hazard controller.
interface pipeline_hazard_ctrl_if;

   logic mem_req;
   logic mem_rdy;

   modport master (output mem_req, input mem_rdy);
   modport slave  (input mem_req, output mem_rdy);

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources read in ID.
module hazard_detect
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_W = REG_W_DEF
) (
   input  logic [REG_W-1:0] ID_s_reg,
   input  logic [REG_W-1:0] ID_t_reg,
   input  logic             ID_use_s,
   input  logic             ID_use_t,
   input  logic             EX_re,
   input  logic             EX_use_dst_reg,
   input  logic [REG_W-1:0] EX_dst_reg,
   output logic             load_use
);

   logic dst_live;
   logic s_hit;
   logic t_hit;

   // Register 0 is hardwired, so a load targeting it never creates a hazard.
   always_comb begin
      dst_live = EX_re && EX_use_dst_reg && (EX_dst_reg != '0);
      s_hit    = ID_use_s && (ID_s_reg == EX_dst_reg);
      t_hit    = ID_use_t && (ID_t_reg == EX_dst_reg);
      load_use = dst_live && (s_hit || t_hit);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, memory wait,
// taken-branch squash and hlt drain.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_W        = REG_W_DEF,
   parameter int unsigned MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [REG_W-1:0]       ID_s_reg,
   input  logic [REG_W-1:0]       ID_t_reg,
   input  logic                   ID_use_s,
   input  logic                   ID_use_t,
   input  logic                   EX_re,
   input  logic                   EX_use_dst_reg,
   input  logic [REG_W-1:0]       EX_dst_reg,
   input  logic                   MEM_re,
   input  logic                   MEM_we,
   input  logic                   MEM_branch_taken,
   input  logic                   MEM_hlt,
   pipeline_hazard_ctrl_if.master mem,
   output logic                   pc_stall,
   output logic                   pc_sel_branch,
   output logic                   stall_if_id,
   output logic                   stall_id_ex,
   output logic                   stall_ex_mem,
   output logic                   flush_if_id,
   output logic                   flush_id_ex,
   output logic                   flush_ex_mem,
   output logic                   flush_mem_wb,
   output logic                   halted,
   output logic                   mem_err
);

   localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic                halted_q, halted_d;
   logic                mem_err_q, mem_err_d;
   logic                load_use;
   logic                mem_pend;
   logic                mem_hold;
   ctrl_t               ctrl;

   hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
      .ID_s_reg       (ID_s_reg),
      .ID_t_reg       (ID_t_reg),
      .ID_use_s       (ID_use_s),
      .ID_use_t       (ID_use_t),
      .EX_re          (EX_re),
      .EX_use_dst_reg (EX_use_dst_reg),
      .EX_dst_reg     (EX_dst_reg),
      .load_use       (load_use)
   );

   assign mem_pend = MEM_re | MEM_we;
   assign mem_hold = mem_pend && !mem.mem_rdy;

   // State, counters and sticky flags; reset returns straight to RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         drain_cnt_q <= '0;
         halted_q    <= 1'b0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         halted_q    <= halted_d;
         mem_err_q   <= mem_err_d;
      end
   end

   // Next-state: the first unanswered request cycle in RUN already counts as a wait cycle.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      drain_cnt_d = drain_cnt_q;
      halted_d    = halted_q;
      mem_err_d   = mem_err_q;
      case (state_q)
         RUN: begin
            if (mem_hold) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end else if (MEM_hlt) begin
               state_d     = DRAIN;
               drain_cnt_d = '0;
            end
         end
         MEM_WAIT: begin
            if (mem.mem_rdy) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_MAX) begin
               state_d   = HALTED;
               mem_err_d = 1'b1;
               halted_d  = 1'b1;
            end else if (wait_cnt_q != '1) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d  = HALTED;
               halted_d = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         HALTED: state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   // Output decode; priority HALTED > memory wait > hlt > branch > load-use, all low in reset.
   always_comb begin
      ctrl = '0;
      if (rst_n) begin
         case (state_q)
            RUN: begin
               ctrl.mem_req = mem_pend;
               if (mem_hold) begin
                  ctrl.pc_stall     = 1'b1;
                  ctrl.stall_if_id  = 1'b1;
                  ctrl.stall_id_ex  = 1'b1;
                  ctrl.stall_ex_mem = 1'b1;
                  ctrl.flush_mem_wb = 1'b1;
               end else if (MEM_hlt) begin
                  ctrl.pc_stall     = 1'b1;
                  ctrl.flush_if_id  = 1'b1;
                  ctrl.flush_id_ex  = 1'b1;
                  ctrl.flush_ex_mem = 1'b1;
               end else if (MEM_branch_taken) begin
                  ctrl.pc_sel_branch = 1'b1;
                  ctrl.flush_if_id   = 1'b1;
                  ctrl.flush_id_ex   = 1'b1;
                  ctrl.flush_ex_mem  = 1'b1;
               end else if (load_use) begin
                  ctrl.pc_stall    = 1'b1;
                  ctrl.stall_if_id = 1'b1;
                  ctrl.flush_id_ex = 1'b1;
               end
            end
            MEM_WAIT: begin
               ctrl.mem_req = 1'b1;
               if (!mem.mem_rdy) begin
                  ctrl.pc_stall     = 1'b1;
                  ctrl.stall_if_id  = 1'b1;
                  ctrl.stall_id_ex  = 1'b1;
                  ctrl.stall_ex_mem = 1'b1;
                  ctrl.flush_mem_wb = 1'b1;
               end else if (MEM_branch_taken) begin
                  ctrl.pc_sel_branch = 1'b1;
                  ctrl.flush_if_id   = 1'b1;
                  ctrl.flush_id_ex   = 1'b1;
                  ctrl.flush_ex_mem  = 1'b1;
               end
            end
            DRAIN: begin
               ctrl.pc_stall     = 1'b1;
               ctrl.flush_if_id  = 1'b1;
               ctrl.flush_id_ex  = 1'b1;
               ctrl.flush_ex_mem = 1'b1;
            end
            HALTED: begin
               ctrl.pc_stall     = 1'b1;
               ctrl.flush_if_id  = 1'b1;
               ctrl.flush_id_ex  = 1'b1;
               ctrl.flush_ex_mem = 1'b1;
               ctrl.flush_mem_wb = 1'b1;
            end
            default: ctrl = '0;
         endcase
      end
   end

   assign mem.mem_req     = ctrl.mem_req;
   assign pc_stall        = ctrl.pc_stall;
   assign pc_sel_branch   = ctrl.pc_sel_branch;
   assign stall_if_id     = ctrl.stall_if_id;
   assign stall_id_ex     = ctrl.stall_id_ex;
   assign stall_ex_mem    = ctrl.stall_ex_mem;
   assign flush_if_id     = ctrl.flush_if_id;
   assign flush_id_ex     = ctrl.flush_id_ex;
   assign flush_ex_mem    = ctrl.flush_ex_mem;
   assign flush_mem_wb    = ctrl.flush_mem_wb;
   assign halted          = halted_q;
   assign mem_err         = mem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned REG_W        = 5;
   localparam int unsigned MEM_TIMEOUT  = 4;
   localparam int unsigned DRAIN_CYCLES = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [REG_W-1:0] ID_s_reg, ID_t_reg, EX_dst_reg;
   logic             ID_use_s, ID_use_t, EX_re, EX_use_dst_reg;
   logic             MEM_re, MEM_we, MEM_branch_taken, MEM_hlt;
   logic             pc_stall, pc_sel_branch;
   logic             stall_if_id, stall_id_ex, stall_ex_mem;
   logic             flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
   logic             halted, mem_err;

   int unsigned vectors;
   int unsigned miscompares;

   // Observed/expected layout:
   // {mem_req, pc_stall, pc_sel_branch, stall_if_id, stall_id_ex, stall_ex_mem,
   //  flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, halted, mem_err}
   logic [11:0] act;
   logic [11:0] exp_v;

   // Model: memory-wait flag with cycles waited, drain cycles left, sticky flags.
   bit          m_wait;
   int unsigned m_waited;
   int unsigned m_drain_left;
   bit          m_halt;
   bit          m_err;

   pipeline_hazard_ctrl_if mem_bus ();

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .REG_W        (REG_W),
      .MEM_TIMEOUT  (MEM_TIMEOUT),
      .DRAIN_CYCLES (DRAIN_CYCLES)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ID_s_reg         (ID_s_reg),
      .ID_t_reg         (ID_t_reg),
      .ID_use_s         (ID_use_s),
      .ID_use_t         (ID_use_t),
      .EX_re            (EX_re),
      .EX_use_dst_reg   (EX_use_dst_reg),
      .EX_dst_reg       (EX_dst_reg),
      .MEM_re           (MEM_re),
      .MEM_we           (MEM_we),
      .MEM_branch_taken (MEM_branch_taken),
      .MEM_hlt          (MEM_hlt),
      .mem              (mem_bus),
      .pc_stall         (pc_stall),
      .pc_sel_branch    (pc_sel_branch),
      .stall_if_id      (stall_if_id),
      .stall_id_ex      (stall_id_ex),
      .stall_ex_mem     (stall_ex_mem),
      .flush_if_id      (flush_if_id),
      .flush_id_ex      (flush_id_ex),
      .flush_ex_mem     (flush_ex_mem),
      .flush_mem_wb     (flush_mem_wb),
      .halted           (halted),
      .mem_err          (mem_err)
   );

   assign act = {mem_bus.mem_req, pc_stall, pc_sel_branch, stall_if_id, stall_id_ex,
                 stall_ex_mem, flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
                 halted, mem_err};

   task automatic model_reset();
      m_wait       = 1'b0;
      m_waited     = 0;
      m_drain_left = 0;
      m_halt       = 1'b0;
      m_err        = 1'b0;
   endtask

   function automatic logic [11:0] model_out();
      logic [11:0] e;
      logic        pend, lu;
      e    = '0;
      pend = MEM_re | MEM_we;
      lu   = EX_re && EX_use_dst_reg && (EX_dst_reg != 0) &&
             ((ID_use_s && ID_s_reg == EX_dst_reg) || (ID_use_t && ID_t_reg == EX_dst_reg));
      if (!rst_n) return '0;
      e[1] = m_halt;
      e[0] = m_err;
      if (m_halt) begin
         e[10]  = 1'b1;
         e[5:2] = 4'b1111;
      end else if (m_drain_left != 0) begin
         e[10]  = 1'b1;
         e[5:3] = 3'b111;
      end else begin
         e[11] = pend | m_wait;
         if ((m_wait || pend) && !mem_bus.mem_rdy) begin
            e[10] = 1'b1; e[8:6] = 3'b111; e[2] = 1'b1;
         end else if (!m_wait && MEM_hlt) begin
            e[10] = 1'b1; e[5:3] = 3'b111;
         end else if (MEM_branch_taken) begin
            e[9] = 1'b1; e[5:3] = 3'b111;
         end else if (!m_wait && lu) begin
            e[10] = 1'b1; e[8] = 1'b1; e[4] = 1'b1;
         end
      end
      return e;
   endfunction

   task automatic model_step();
      if (!rst_n) begin
         model_reset();
      end else if (m_halt) begin
         m_halt = 1'b1;
      end else if (m_drain_left != 0) begin
         m_drain_left--;
         if (m_drain_left == 0) m_halt = 1'b1;
      end else if (m_wait) begin
         if (mem_bus.mem_rdy) begin
            m_wait = 1'b0; m_waited = 0;
         end else if (m_waited == MEM_TIMEOUT) begin
            m_wait = 1'b0; m_halt = 1'b1; m_err = 1'b1;
         end else begin
            m_waited++;
         end
      end else if ((MEM_re || MEM_we) && !mem_bus.mem_rdy) begin
         m_wait = 1'b1; m_waited = 1;
      end else if (MEM_hlt) begin
         m_drain_left = DRAIN_CYCLES;
      end
   endtask

   // Advance model and clock; inputs change 1 time unit after the edge.
   task automatic advance();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ID_s_reg = '0; ID_t_reg = '0; EX_dst_reg = '0;
      ID_use_s = 1'b0; ID_use_t = 1'b0; EX_re = 1'b0; EX_use_dst_reg = 1'b0;
      MEM_re = 1'b0; MEM_we = 1'b0; MEM_branch_taken = 1'b0; MEM_hlt = 1'b0;
      mem_bus.mem_rdy = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic rand_lu_inputs();
      ID_s_reg       = REG_W'($urandom_range(0, 3));
      ID_t_reg       = REG_W'($urandom_range(0, 3));
      EX_dst_reg     = REG_W'($urandom_range(0, 3));
      ID_use_s       = 1'($urandom_range(0, 1));
      ID_use_t       = 1'($urandom_range(0, 1));
      EX_re          = 1'($urandom_range(0, 1));
      EX_use_dst_reg = 1'($urandom_range(0, 1));
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      model_step();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int unsigned c = 0; c < 3; c++) begin
         rand_lu_inputs();
         MEM_re = 1'b1; MEM_branch_taken = 1'b1; MEM_hlt = 1'b1;
         @(negedge clk);
         vectors++;
         if (act !== 12'b0) begin
            miscompares++;
            $display("FAIL reset_outputs cyc=%0d act=%b exp=%b", c, act, 12'b0);
         end
         advance();
      end
      clear_inputs();
      @(negedge clk);
      exp_v = model_out();
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL reset_idle act=%b exp=%b", act, exp_v);
      end
      advance();
   endtask

   task automatic test_load_use();
      clear_inputs();
      EX_re = 1'b1; EX_use_dst_reg = 1'b1; EX_dst_reg = 5; ID_use_s = 1'b1; ID_s_reg = 5;
      @(negedge clk);
      vectors++;
      if (act !== 12'b010100010000) begin
         miscompares++;
         $display("FAIL load_use_hit act=%b exp=%b", act, 12'b010100010000);
      end
      advance();
      EX_dst_reg = 0; ID_s_reg = 0;
      @(negedge clk);
      vectors++;
      if (act !== 12'b0) begin
         miscompares++;
         $display("FAIL load_use_reg0 act=%b exp=%b", act, 12'b0);
      end
      advance();
      for (int unsigned c = 0; c < 200; c++) begin
         rand_lu_inputs();
         @(negedge clk);
         exp_v = model_out();
         vectors++;
         if (act !== exp_v) begin
            miscompares++;
            $display("FAIL load_use_rand cyc=%0d act=%b exp=%b", c, act, exp_v);
         end
         advance();
      end
      clear_inputs();
   endtask

   task automatic test_mem_wait();
      int unsigned req_cnt, hold_cnt;
      req_cnt = 0; hold_cnt = 0;
      clear_inputs();
      for (int unsigned c = 0; c < 4; c++) begin
         MEM_re = 1'b1;
         mem_bus.mem_rdy = (c == 3);
         @(negedge clk);
         exp_v = model_out();
         vectors++;
         if (act !== exp_v) begin
            miscompares++;
            $display("FAIL mem_wait_cyc cyc=%0d act=%b exp=%b", c, act, exp_v);
         end
         if (mem_bus.mem_req) req_cnt++;
         if (stall_ex_mem && flush_mem_wb) hold_cnt++;
         advance();
      end
      clear_inputs();
      @(negedge clk);
      vectors++;
      if (act !== 12'b0) begin
         miscompares++;
         $display("FAIL mem_wait_back_to_run act=%b exp=%b", act, 12'b0);
      end
      vectors++;
      if (req_cnt != 4) begin
         miscompares++;
         $display("FAIL mem_wait_req_cycles act=%0d exp=4", req_cnt);
      end
      vectors++;
      if (hold_cnt != 3) begin
         miscompares++;
         $display("FAIL mem_wait_hold_cycles act=%0d exp=3", hold_cnt);
      end
      advance();
   endtask

   task automatic test_timeout();
      int unsigned first_err;
      first_err = 99;
      clear_inputs();
      for (int unsigned c = 0; c < 9; c++) begin
         MEM_we = 1'b1;
         @(negedge clk);
         exp_v = model_out();
         vectors++;
         if (act !== exp_v) begin
            miscompares++;
            $display("FAIL timeout_cyc cyc=%0d act=%b exp=%b", c, act, exp_v);
         end
         if (mem_err && halted && first_err == 99) first_err = c;
         advance();
      end
      vectors++;
      if (first_err != MEM_TIMEOUT + 1) begin
         miscompares++;
         $display("FAIL timeout_err_cycle act=%0d exp=%0d", first_err, MEM_TIMEOUT + 1);
      end
      pulse_reset();
      @(negedge clk);
      vectors++;
      if (act !== 12'b0) begin
         miscompares++;
         $display("FAIL timeout_cleared act=%b exp=%b", act, 12'b0);
      end
      advance();
   endtask

   task automatic test_branch();
      clear_inputs();
      EX_re = 1'b1; EX_use_dst_reg = 1'b1; EX_dst_reg = 3; ID_use_t = 1'b1; ID_t_reg = 3;
      MEM_branch_taken = 1'b1;
      @(negedge clk);
      vectors++;
      if (act !== 12'b001000111000) begin
         miscompares++;
         $display("FAIL branch_over_lu act=%b exp=%b", act, 12'b001000111000);
      end
      advance();
      // Branch waits behind a pending load, then fires on the completion cycle.
      clear_inputs();
      for (int unsigned c = 0; c < 3; c++) begin
         MEM_re = 1'b1; MEM_branch_taken = 1'b1;
         mem_bus.mem_rdy = (c == 2);
         @(negedge clk);
         exp_v = model_out();
         vectors++;
         if (act !== exp_v) begin
            miscompares++;
            $display("FAIL branch_mem_cyc cyc=%0d act=%b exp=%b", c, act, exp_v);
         end
         if (c == 2) begin
            vectors++;
            if (act !== 12'b101000111000) begin
               miscompares++;
               $display("FAIL branch_mem_done act=%b exp=%b", act, 12'b101000111000);
            end
         end
         advance();
      end
      clear_inputs();
   endtask

   task automatic test_hlt();
      int unsigned first_halt;
      first_halt = 99;
      clear_inputs();
      for (int unsigned c = 0; c < 6; c++) begin
         MEM_hlt = (c == 0);
         MEM_branch_taken = (c == 0);
         @(negedge clk);
         exp_v = model_out();
         vectors++;
         if (act !== exp_v) begin
            miscompares++;
            $display("FAIL hlt_cyc cyc=%0d act=%b exp=%b", c, act, exp_v);
         end
         if (halted && first_halt == 99) first_halt = c;
         advance();
      end
      // hlt cycle, then DRAIN_CYCLES drain cycles, then halted.
      vectors++;
      if (first_halt != DRAIN_CYCLES + 1) begin
         miscompares++;
         $display("FAIL hlt_halted_cycle act=%0d exp=%0d", first_halt, DRAIN_CYCLES + 1);
      end
      pulse_reset();
      @(negedge clk);
      vectors++;
      if (halted !== 1'b0) begin
         miscompares++;
         $display("FAIL hlt_reset_clears act=%b exp=0", halted);
      end
      advance();
   endtask

   task automatic test_reset_mid_wait();
      clear_inputs();
      MEM_re = 1'b1;
      advance();
      advance();
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (mem_bus.mem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_async_req act=%b exp=0", mem_bus.mem_req);
      end
      model_reset();
      @(posedge clk);
      #1;
      clear_inputs();
      @(negedge clk);
      vectors++;
      if (act !== 12'b0) begin
         miscompares++;
         $display("FAIL reset_mid_wait_run act=%b exp=%b", act, 12'b0);
      end
      advance();
   endtask

   task automatic test_random();
      clear_inputs();
      for (int unsigned c = 0; c < 3000; c++) begin
         rand_lu_inputs();
         MEM_re           = ($urandom_range(0, 5) == 0);
         MEM_we           = ($urandom_range(0, 7) == 0);
         MEM_branch_taken = ($urandom_range(0, 5) == 0);
         MEM_hlt          = ($urandom_range(0, 40) == 0);
         mem_bus.mem_rdy  = ($urandom_range(0, 2) == 0);
         rst_n            = !($urandom_range(0, 30) == 0);
         @(negedge clk);
         exp_v = model_out();
         vectors++;
         if (act !== exp_v) begin
            miscompares++;
            $display("FAIL random cyc=%0d act=%b exp=%b", c, act, exp_v);
         end
         advance();
      end
      clear_inputs();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      test_reset();
      test_load_use();
      test_mem_wait();
      test_timeout();
      test_branch();
      test_hlt();
      test_reset_mid_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
